// File: rtl/clint_axi_initiator_pkg.sv
// Shared definitions for the CLINT AXI initiator: FSM state encoding,
// CLINT register offsets and the AXI constants the initiator drives or checks.
package clint_axi_initiator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_READ,
    ST_RRESP,
    ST_DONE
  } state_t;

  // CLINT register offsets (relative to the CLINT base)
  localparam logic [15:0] CLINT_MSIP     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP = 16'h4000;
  localparam logic [15:0] CLINT_MTIME    = 16'hBFF8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // 8-byte beats: the initiator only supports a 64-bit data bus
  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

endpackage

// File: rtl/clint_axi_initiator.sv
// clint_axi_initiator
// Single-outstanding AXI4 master turning register read/write requests into
// single-beat AXI4 transactions toward the CLINT slave port.
// Ports:
//   aclk, areset           clock, asynchronous active-high reset
//   req_*                  request in (valid/ready, write, addr, wdata, strb)
//   rsp_*                  response out (valid/ready, rdata, resp)
//   m_axi_clint_aw/w/b/ar/r  AXI4 master channels
module clint_axi_initiator
  import clint_axi_initiator_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_USER_WIDTH = 1,
  parameter logic [AXI_ID_WIDTH-1:0] TXN_ID = '0
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] req_strb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_clint_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_clint_awaddr,
  output logic [7:0]                  m_axi_clint_awlen,
  output logic [2:0]                  m_axi_clint_awsize,
  output logic [1:0]                  m_axi_clint_awburst,
  output logic                        m_axi_clint_awlock,
  output logic [3:0]                  m_axi_clint_awcache,
  output logic [2:0]                  m_axi_clint_awprot,
  output logic [3:0]                  m_axi_clint_awqos,
  output logic [3:0]                  m_axi_clint_awregion,
  output logic [AXI_USER_WIDTH-1:0]   m_axi_clint_awuser,
  output logic                        m_axi_clint_awvalid,
  input  logic                        m_axi_clint_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_clint_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_clint_wstrb,
  output logic                        m_axi_clint_wlast,
  output logic [AXI_USER_WIDTH-1:0]   m_axi_clint_wuser,
  output logic                        m_axi_clint_wvalid,
  input  logic                        m_axi_clint_wready,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_clint_bid,
  input  logic [1:0]                  m_axi_clint_bresp,
  input  logic [AXI_USER_WIDTH-1:0]   m_axi_clint_buser,
  input  logic                        m_axi_clint_bvalid,
  output logic                        m_axi_clint_bready,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_clint_arid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_clint_araddr,
  output logic [7:0]                  m_axi_clint_arlen,
  output logic [2:0]                  m_axi_clint_arsize,
  output logic [1:0]                  m_axi_clint_arburst,
  output logic                        m_axi_clint_arlock,
  output logic [3:0]                  m_axi_clint_arcache,
  output logic [2:0]                  m_axi_clint_arprot,
  output logic [3:0]                  m_axi_clint_arqos,
  output logic [3:0]                  m_axi_clint_arregion,
  output logic [AXI_USER_WIDTH-1:0]   m_axi_clint_aruser,
  output logic                        m_axi_clint_arvalid,
  input  logic                        m_axi_clint_arready,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_clint_rid,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_clint_rdata,
  input  logic [1:0]                  m_axi_clint_rresp,
  input  logic                        m_axi_clint_rlast,
  input  logic [AXI_USER_WIDTH-1:0]   m_axi_clint_ruser,
  input  logic                        m_axi_clint_rvalid,
  output logic                        m_axi_clint_rready
);

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_fin;
  logic   w_fin;

  // Fixed single-beat attributes
  assign m_axi_clint_awid     = TXN_ID;
  assign m_axi_clint_awlen    = 8'd0;
  assign m_axi_clint_awsize   = AXI_SIZE_8B;
  assign m_axi_clint_awburst  = BURST_INCR;
  assign m_axi_clint_awlock   = 1'b0;
  assign m_axi_clint_awcache  = 4'd0;
  assign m_axi_clint_awprot   = 3'd0;
  assign m_axi_clint_awqos    = 4'd0;
  assign m_axi_clint_awregion = 4'd0;
  assign m_axi_clint_awuser   = '0;
  assign m_axi_clint_wlast    = 1'b1;
  assign m_axi_clint_wuser    = '0;
  assign m_axi_clint_arid     = TXN_ID;
  assign m_axi_clint_arlen    = 8'd0;
  assign m_axi_clint_arsize   = AXI_SIZE_8B;
  assign m_axi_clint_arburst  = BURST_INCR;
  assign m_axi_clint_arlock   = 1'b0;
  assign m_axi_clint_arcache  = 4'd0;
  assign m_axi_clint_arprot   = 3'd0;
  assign m_axi_clint_arqos    = 4'd0;
  assign m_axi_clint_arregion = 4'd0;
  assign m_axi_clint_aruser   = '0;

  // User sideband on B/R carries nothing the initiator acts on
  logic unused_user;
  assign unused_user = ^{m_axi_clint_buser, m_axi_clint_ruser};

  // AW and W complete independently; a channel counts as finished once its
  // handshake has happened in an earlier cycle or is happening now.
  always_comb begin
    aw_fin = aw_done | (m_axi_clint_awvalid & m_axi_clint_awready);
    w_fin  = w_done  | (m_axi_clint_wvalid  & m_axi_clint_wready);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state               <= ST_IDLE;
      aw_done             <= 1'b0;
      w_done              <= 1'b0;
      req_ready           <= 1'b1;
      rsp_valid           <= 1'b0;
      rsp_rdata           <= '0;
      rsp_resp            <= RESP_OKAY;
      m_axi_clint_awaddr  <= '0;
      m_axi_clint_awvalid <= 1'b0;
      m_axi_clint_wdata   <= '0;
      m_axi_clint_wstrb   <= '0;
      m_axi_clint_wvalid  <= 1'b0;
      m_axi_clint_bready  <= 1'b0;
      m_axi_clint_araddr  <= '0;
      m_axi_clint_arvalid <= 1'b0;
      m_axi_clint_rready  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (req_write) begin
              m_axi_clint_awaddr  <= req_addr;
              m_axi_clint_wdata   <= req_wdata;
              m_axi_clint_wstrb   <= req_strb;
              m_axi_clint_awvalid <= 1'b1;
              m_axi_clint_wvalid  <= 1'b1;
              aw_done             <= 1'b0;
              w_done              <= 1'b0;
              state               <= ST_WRITE;
            end else begin
              m_axi_clint_araddr  <= req_addr;
              m_axi_clint_arvalid <= 1'b1;
              state               <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (m_axi_clint_awvalid && m_axi_clint_awready) m_axi_clint_awvalid <= 1'b0;
          if (m_axi_clint_wvalid && m_axi_clint_wready)   m_axi_clint_wvalid  <= 1'b0;
          aw_done <= aw_fin;
          w_done  <= w_fin;
          if (aw_fin && w_fin) begin
            m_axi_clint_bready <= 1'b1;
            state              <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (m_axi_clint_bvalid) begin
            m_axi_clint_bready <= 1'b0;
            rsp_rdata          <= '0;
            rsp_resp           <= (m_axi_clint_bid != TXN_ID) ? RESP_SLVERR : m_axi_clint_bresp;
            rsp_valid          <= 1'b1;
            state              <= ST_DONE;
          end
        end
        ST_READ: begin
          if (m_axi_clint_arready) begin
            m_axi_clint_arvalid <= 1'b0;
            m_axi_clint_rready  <= 1'b1;
            state               <= ST_RRESP;
          end
        end
        ST_RRESP: begin
          if (m_axi_clint_rvalid) begin
            m_axi_clint_rready <= 1'b0;
            // Data is kept even when the beat is flagged as a protocol fault
            rsp_rdata          <= m_axi_clint_rdata;
            rsp_resp           <= ((m_axi_clint_rid != TXN_ID) || !m_axi_clint_rlast)
                                  ? RESP_SLVERR : m_axi_clint_rresp;
            rsp_valid          <= 1'b1;
            state              <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clint_axi_initiator.sv
// Testbench for clint_axi_initiator: directed CLINT accesses plus randomized
// transactions against an in-bench AXI slave with programmable delays/faults.
module tb_clint_axi_initiator;

  logic        aclk = 1'b0;
  logic        areset;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_strb;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [5:0]  awid, arid, bid, rid;
  logic [63:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, arlock, wlast, rlast;
  logic [3:0]  awcache, arcache, awqos, arqos, awregion, arregion;
  logic [0:0]  awuser, aruser, wuser, buser, ruser;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  clint_axi_initiator dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_clint_awid(awid), .m_axi_clint_awaddr(awaddr), .m_axi_clint_awlen(awlen),
    .m_axi_clint_awsize(awsize), .m_axi_clint_awburst(awburst), .m_axi_clint_awlock(awlock),
    .m_axi_clint_awcache(awcache), .m_axi_clint_awprot(awprot), .m_axi_clint_awqos(awqos),
    .m_axi_clint_awregion(awregion), .m_axi_clint_awuser(awuser),
    .m_axi_clint_awvalid(awvalid), .m_axi_clint_awready(awready),
    .m_axi_clint_wdata(wdata), .m_axi_clint_wstrb(wstrb), .m_axi_clint_wlast(wlast),
    .m_axi_clint_wuser(wuser), .m_axi_clint_wvalid(wvalid), .m_axi_clint_wready(wready),
    .m_axi_clint_bid(bid), .m_axi_clint_bresp(bresp), .m_axi_clint_buser(buser),
    .m_axi_clint_bvalid(bvalid), .m_axi_clint_bready(bready),
    .m_axi_clint_arid(arid), .m_axi_clint_araddr(araddr), .m_axi_clint_arlen(arlen),
    .m_axi_clint_arsize(arsize), .m_axi_clint_arburst(arburst), .m_axi_clint_arlock(arlock),
    .m_axi_clint_arcache(arcache), .m_axi_clint_arprot(arprot), .m_axi_clint_arqos(arqos),
    .m_axi_clint_arregion(arregion), .m_axi_clint_aruser(aruser),
    .m_axi_clint_arvalid(arvalid), .m_axi_clint_arready(arready),
    .m_axi_clint_rid(rid), .m_axi_clint_rdata(rdata), .m_axi_clint_rresp(rresp),
    .m_axi_clint_rlast(rlast), .m_axi_clint_ruser(ruser),
    .m_axi_clint_rvalid(rvalid), .m_axi_clint_rready(rready)
  );

  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: response code and data the requester must see, from the slave's reply.
  function automatic logic [65:0] model(input bit wr, input logic [5:0] id,
                                        input logic [1:0] resp, input bit last,
                                        input logic [63:0] d);
    bit fault;
    fault = (id != 6'd0) || (!wr && !last);
    return {fault ? 2'b10 : resp, wr ? 64'h0 : d};
  endfunction

  task automatic clear_inputs();
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_strb = '0;
    rsp_ready = 0;
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; bid = '0; bresp = '0; buser = '0;
    rvalid = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; ruser = '0;
  endtask

  // One complete request/response. Called at a negedge with the DUT idle.
  // d_a: AW (or AR) ready delay, d_w: W ready delay, d_r: B/R delay after
  // the address/data phase, hold: cycles rsp_ready stays low.
  task automatic run_txn(input string nm, input bit wr, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [7:0] strb,
                         input int d_a, input int d_w, input int d_r,
                         input logic [5:0] id_ret, input logic [1:0] resp_ret,
                         input bit last_ret, input logic [63:0] rd_ret, input int hold);
    logic [65:0] exp;
    logic [63:0] rsp_d0;
    logic [1:0]  rsp_r0;
    int aw_n = 0, w_n = 0, ar_n = 0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0;
    int hs_cyc = -1, rsp_cyc = -1;
    int unstable = 0, proto = 0, field_err = 0, exp_lat;
    bit req_hs = 0, resp_sent = 0, fin = 0;

    exp     = model(wr, id_ret, resp_ret, last_ret, rd_ret);
    exp_lat = wr ? (((d_a > d_w) ? d_a : d_w) + d_r + 3) : (d_a + d_r + 3);
    rsp_d0 = '0; rsp_r0 = '0;
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd; req_strb = strb;

    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (req_hs) req_valid = 0;
      // response channel: only after the address (and data) phase completed
      if (resp_sent) begin
        bvalid = 0; rvalid = 0;
        if (bready || rready) proto++;
      end else if (wr) begin
        if (!(aw_n > 0 && w_n > 0)) begin
          if (bready) proto++;
        end else if (r_wait >= d_r) begin
          bvalid = 1; bid = id_ret; bresp = resp_ret;
          if (bready) resp_sent = 1;
        end else r_wait++;
        if (rready) proto++;
      end else begin
        if (ar_n == 0) begin
          if (rready) proto++;
        end else if (r_wait >= d_r) begin
          rvalid = 1; rid = id_ret; rresp = resp_ret; rlast = last_ret; rdata = rd_ret;
          if (rready) resp_sent = 1;
        end else r_wait++;
        if (bready) proto++;
      end
      // address / data channels
      awready = awvalid && (aw_wait >= d_a);
      if (awvalid) begin
        if (awready) begin
          aw_n++;
          if (awaddr !== addr || awlen !== 8'd0 || awsize !== 3'd3 || awburst !== 2'b01 ||
              awid !== 6'd0 || {awlock, awcache, awprot, awqos, awregion, awuser} !== '0)
            field_err++;
        end else aw_wait++;
      end
      wready = wvalid && (w_wait >= d_w);
      if (wvalid) begin
        if (wready) begin
          w_n++;
          if (wdata !== wd || wstrb !== strb || wlast !== 1'b1 || wuser !== '0) field_err++;
        end else w_wait++;
      end
      arready = arvalid && (ar_wait >= d_a);
      if (arvalid) begin
        if (arready) begin
          ar_n++;
          if (araddr !== addr || arlen !== 8'd0 || arsize !== 3'd3 || arburst !== 2'b01 ||
              arid !== 6'd0 || {arlock, arcache, arprot, arqos, arregion, aruser} !== '0)
            field_err++;
        end else ar_wait++;
      end
      // requester side
      if (rsp_valid) begin
        if (rsp_cyc < 0) begin
          rsp_cyc = cyc; rsp_d0 = rsp_rdata; rsp_r0 = rsp_resp;
        end else if (rsp_rdata !== rsp_d0 || rsp_resp !== rsp_r0) unstable++;
        if (req_ready || awvalid || wvalid || arvalid) unstable++;
        rsp_ready = (cyc - rsp_cyc >= hold);
        if (rsp_ready) fin = 1;
      end else if (rsp_cyc >= 0) unstable++;
      if (!req_hs && req_valid && req_ready) begin
        req_hs = 1; hs_cyc = cyc;
      end
      @(posedge aclk);
      @(negedge aclk);
    end
    rsp_ready = 0; awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;

    if (!fin) begin
      chk({nm, "_timeout"}, 64'(rsp_cyc), 64'(hs_cyc + exp_lat));
      areset = 1; @(negedge aclk); areset = 0; req_valid = 0;
      return;
    end
    chk({nm, "_rdata"}, rsp_d0, exp[63:0]);
    chk({nm, "_resp"}, 64'(rsp_r0), 64'(exp[65:64]));
    chk({nm, "_latency"}, 64'(rsp_cyc - hs_cyc), 64'(exp_lat));
    chk({nm, "_aw_count"}, 64'(aw_n), wr ? 64'd1 : 64'd0);
    chk({nm, "_w_count"}, 64'(w_n), wr ? 64'd1 : 64'd0);
    chk({nm, "_ar_count"}, 64'(ar_n), wr ? 64'd0 : 64'd1);
    chk({nm, "_fields"}, 64'(field_err), 64'd0);
    chk({nm, "_hold_stable"}, 64'(unstable), 64'd0);
    chk({nm, "_ready_window"}, 64'(proto), 64'd0);
    chk({nm, "_idle_after"}, {62'd0, req_ready, rsp_valid}, 64'd2);
  endtask

  initial begin
    clear_inputs();
    areset = 1;
    repeat (3) @(negedge aclk);
    chk("rst_valids", {58'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_payload", awaddr | araddr | wdata | 64'(wstrb) | rsp_rdata, 64'd0);
    chk("rst_resp", 64'(rsp_resp), 64'd0);
    areset = 0;
    @(negedge aclk);

    // msip write, zero-wait slave
    run_txn("msip_wr", 1, 64'h0000_0000_0200_0000, 64'h1, 8'h0F, 0, 0, 0,
            6'd0, 2'b00, 1, 64'h0, 0);
    // mtime read
    run_txn("mtime_rd", 0, 64'h0000_0000_0200_BFF8, 64'h0, 8'h00, 0, 0, 0,
            6'd0, 2'b00, 1, 64'h1234_5678_9ABC_DEF0, 0);
    // AW/W ordering: W late, AW late, same cycle
    run_txn("w_late", 1, 64'h0200_4000, 64'hAAAA_5555_0000_FFFF, 8'hFF, 0, 4, 0,
            6'd0, 2'b00, 1, 64'h0, 0);
    run_txn("aw_late", 1, 64'h0200_4008, 64'h0123_4567_89AB_CDEF, 8'hF0, 4, 0, 0,
            6'd0, 2'b00, 1, 64'h0, 0);
    run_txn("aw_w_same", 1, 64'h0200_4000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 2, 2, 1,
            6'd0, 2'b00, 1, 64'h0, 0);
    // faults
    run_txn("bresp_slverr", 1, 64'h0200_0000, 64'h0, 8'h0F, 0, 0, 0,
            6'd0, 2'b10, 1, 64'h0, 0);
    run_txn("rid_mismatch", 0, 64'h0200_BFF8, 64'h0, 8'h00, 0, 0, 0,
            6'd5, 2'b00, 1, 64'h0BAD_0BAD_0BAD_0BAD, 0);
    run_txn("rlast_low", 0, 64'h0200_BFF8, 64'h0, 8'h00, 1, 0, 2,
            6'd0, 2'b00, 0, 64'h5A5A_5A5A_5A5A_5A5A, 0);
    // requester back-pressure
    run_txn("rsp_hold", 0, 64'h0200_4000, 64'h0, 8'h00, 0, 0, 0,
            6'd0, 2'b00, 1, 64'hFEDC_BA98_7654_3210, 10);

    // reset while AW is outstanding
    req_valid = 1; req_write = 1; req_addr = 64'h0200_0000; req_wdata = 64'h1; req_strb = 8'h0F;
    @(posedge aclk); @(negedge aclk);
    req_valid = 0;
    repeat (2) @(negedge aclk);
    chk("midrst_aw_pending", 64'(awvalid), 64'd1);
    areset = 1;
    #1;
    chk("midrst_valids", {58'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    @(negedge aclk);
    areset = 0;
    @(negedge aclk);
    run_txn("post_rst_wr", 1, 64'h0200_0000, 64'h0, 8'h0F, 0, 0, 0,
            6'd0, 2'b00, 1, 64'h0, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit          wr;
      logic [63:0] a, d, rd;
      logic [5:0]  id;
      wr = 1'($urandom_range(0, 1));
      a  = {32'h0, $urandom} & ~64'h7;
      d  = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      id = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      run_txn($sformatf("rand%0d", i), wr, a, d, 8'($urandom_range(0, 255)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
              id, 2'($urandom_range(0, 3)), ($urandom_range(0, 5) != 0), rd,
              int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clint_axi_initiator.md
# clint_axi_initiator

Single-outstanding AXI4 master that turns simple register read/write requests into single-beat AXI4 transactions toward the CLINT's AXI slave port. Used by boot/debug logic to raise software interrupts (msip) and program mtimecmp/read mtime without a core. It sits upstream of the CLINT on the same AXI fabric and returns the read data and response to the requester.

## Interface
- AXI_ADDR_WIDTH, 64, AXI address width
- AXI_DATA_WIDTH, 64, AXI data width (only 64 supported; size field fixed to 3)
- AXI_ID_WIDTH, 6, AXI ID width
- AXI_USER_WIDTH, 1, AXI user width; all user outputs driven 0
- TXN_ID, 0, constant ID driven on awid/arid
---
- aclk  input  1  clock
- areset  input  1  asynchronous, active-high reset
- req_valid  input  1  request valid
- req_ready  output  1  request accepted when valid&ready
- req_write  input  1  1 = write, 0 = read
- req_addr  input  AXI_ADDR_WIDTH  byte address (8-byte aligned)
- req_wdata  input  AXI_DATA_WIDTH  write data
- req_strb  input  AXI_DATA_WIDTH/8  write byte strobes
- rsp_valid  output  1  response valid, held until rsp_ready
- rsp_ready  input  1  requester takes response
- rsp_rdata  output  AXI_DATA_WIDTH  read data (0 for writes)
- rsp_resp  output  2  AXI response code from B/R, or SLVERR on protocol fault
- m_axi_clint_aw*  output/input  AXI4 AW channel (id, addr, len, size, burst, lock, cache, prot, qos, region, user, valid / ready)
- m_axi_clint_w*  output/input  AXI4 W channel (data, strb, last, user, valid / ready)
- m_axi_clint_b*  input/output  AXI4 B channel (id, resp, user, valid / ready)
- m_axi_clint_ar*  output/input  AXI4 AR channel (fields as AW)
- m_axi_clint_r*  input/output  AXI4 R channel (id, data, resp, last, user, valid / ready)

## Operation
- States: IDLE, WRITE (AW and W outstanding), WRESP, READ (AR outstanding), RRESP, DONE.
- IDLE: req_ready=1. On handshake, latch addr/wdata/strb; go WRITE if req_write else READ.
- WRITE: awvalid and wvalid both asserted; each drops independently after its own handshake (aw_done/w_done flags); AW and W may complete in either order or same cycle. Both done -> WRESP.
- WRESP: bready=1; on bvalid latch bresp -> DONE.
- READ: arvalid=1 until arready -> RRESP.
- RRESP: rready=1; on rvalid latch rdata, rresp -> DONE.
- DONE: rsp_valid=1; on rsp_ready -> IDLE. No new request accepted until then.
- Fixed fields: len=0, size=3, burst=INCR(01), wlast=1, lock/cache/prot/qos/region/user=0, awid=arid=TXN_ID.
- Fault: bid/rid != TXN_ID, or rlast=0 -> rsp_resp=SLVERR (2'b10), rdata still latched.
- req_addr low 3 bits forwarded unmodified; alignment is the requester's responsibility.

## Timing
- Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_resp=0, all AXI valid/ready outputs 0, address/data outputs 0.
- All AXI outputs registered; valids assert the cycle after req handshake.
- Valid held stable with stable payload until the matching ready (AXI rule); no combinational path from any ready to any valid.
- Minimum latency with zero-wait slave: write req at cycle 0 -> aw/w handshake cycle 1 -> bvalid cycle 2 -> rsp_valid cycle 3; read same (ar 1, r 2, rsp 3).
- bready/rready only in WRESP/RRESP; B/R arriving earlier is not accepted.
- rsp_rdata/rsp_resp stable while rsp_valid=1.
- areset mid-transaction: immediate return to IDLE, all valids drop; bench must not check the abandoned transfer.

## Structure
- Package clint_axi_initiator_pkg: state enum; CLINT offsets CLINT_MSIP=0x0000, CLINT_MTIMECMP=0x4000, CLINT_MTIME=0xBFF8; AXI constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, BURST_INCR=2'b01.
- Single module, no sub-module.

## Test plan
- Write 0x0000_0000_0200_0000, data 0x1, strb 0x0F, zero-wait slave -> one AW (addr 0x02000000, len 0), one W (wlast 1), rsp_valid at cycle 3 with rsp_resp 0; CLINT ipi_o[0]=1.
- Read 0x0200_BFF8 with slave returning 0x1234_5678_9ABC_DEF0 -> rsp_rdata equals it, rsp_resp 0.
- Write with wready delayed 4 cycles after awready, then reverse order, then same cycle -> exactly one AW and one W each, rsp_resp 0.
- Slave returns bresp=SLVERR; separately rid=5 with TXN_ID=0 -> rsp_resp=2'b10 both cases.
- rsp_ready held low 10 cycles -> rsp_valid/rsp_rdata stable, req_ready=0, no new AW/AR issued.
- areset asserted while awvalid=1 -> next cycle all valids 0, req_ready=1; subsequent write completes normally.
